mcu_exec_unit: RTL and testbench

Parametrised, handshaked execution unit for the MCU. It accepts one command at a time: an ALU operation, iterative divide/remainder, or a load/store to an internal data memory. It returns one response per command, carrying result, error and overflow flags. It is the next-generation replacement for the single-cycle ALU+memory block; it adds backpressure, error reporting and a multi-cycle divider.

---
 rtl/mcu_pkg.sv | 24 ++
 rtl/mcu_divider.sv | 86 ++++++++
 rtl/mcu_exec_unit.sv | 179 +++++++++++++++++
 tb/tb_mcu_exec_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU execution unit: opcode encodings and the
// control state machine encoding.
package mcu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_OR    = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd6;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'd7;
  localparam logic [OP_W-1:0] OP_STORE = 4'd8;
  localparam logic [OP_W-1:0] OP_REM   = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_RESP
  } state_t;

endpackage

// File: rtl/mcu_divider.sv
// Iterative restoring unsigned divider. One quotient bit is produced per
// clock; the first bit is produced in the start cycle itself, so done pulses
// for one cycle after DATA_W step edges. Divisor must be nonzero (the caller
// handles divide-by-zero without starting the divider).
module mcu_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dsr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] src_quo;
  logic [DATA_W-1:0] src_rem;
  logic [DATA_W-1:0] src_dsr;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              fits;

  // One restoring step; on start it operates on the fresh operands.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    src_quo = quo_q;
    src_rem = rem_q;
    src_dsr = dsr_q;
    if (start) begin
      src_quo = dividend;
      src_rem = '0;
      src_dsr = divisor;
    end
    shifted = {src_rem, src_quo[DATA_W-1]};
    diff    = shifted - {1'b0, src_dsr};
    fits    = (shifted >= {1'b0, src_dsr});
  end

  // Datapath and step counter; reset aborts any division in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start || busy_q) begin
        rem_q <= fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_q <= {src_quo[DATA_W-2:0], fits};
        dsr_q <= src_dsr;
      end
      if (start) begin
        cnt_q  <= CNT_W'(1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mcu_exec_unit.sv
// Handshaked MCU execution unit: single-cycle ALU ops, iterative divide and
// remainder, and load/store to an internal data memory. One command in
// flight at a time; one registered response per command.
module mcu_exec_unit
  import mcu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_ovf
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t state_q;
  state_t state_d;

  logic              accept;
  logic              div_op;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_rem;
  logic              is_rem_q;

  logic              addr_ok;
  logic [MEM_AW-1:0] mem_idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   res_data;
  logic                res_err;
  logic                res_ovf;

  assign div_op  = (cmd_op == OP_DIV) || (cmd_op == OP_REM);
  assign addr_ok = (int'(cmd_addr) < MEM_DEPTH);
  assign mem_idx = cmd_addr[MEM_AW-1:0];
  assign sum     = {1'b0, cmd_a} + {1'b0, cmd_b};
  assign prod    = {{DATA_W{1'b0}}, cmd_a} * {{DATA_W{1'b0}}, cmd_b};

  // Control state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = div_start ? S_DIV : S_RESP;
      // The divider cannot stop without done; fall back to IDLE if it ever does.
      S_DIV:  if (div_done) state_d = S_RESP;
              else if (!div_busy) state_d = S_IDLE;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded controls: handshake, divider launch and memory write.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    accept    = cmd_valid && cmd_ready;
    div_start = accept && div_op && (cmd_b != '0);
    mem_we    = accept && reset && (cmd_op == OP_STORE) && addr_ok;
  end

  // Single-cycle result for every non-running command.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    res_ovf  = 1'b0;
    case (cmd_op)
      OP_ADD: begin
        res_data = sum[DATA_W-1:0];
        res_ovf  = sum[DATA_W];
      end
      OP_SUB: begin
        res_data = cmd_a - cmd_b;
        res_ovf  = (cmd_a < cmd_b);
      end
      OP_MUL: begin
        res_data = prod[DATA_W-1:0];
        res_ovf  = |prod[2*DATA_W-1:DATA_W];
      end
      // Only reached with a zero divisor; nonzero divisors go to the divider.
      OP_DIV: begin
        res_data = '1;
        res_err  = 1'b1;
      end
      OP_REM: begin
        res_data = cmd_a;
        res_err  = 1'b1;
      end
      OP_AND: res_data = cmd_a & cmd_b;
      OP_OR:  res_data = cmd_a | cmd_b;
      OP_XOR: res_data = cmd_a ^ cmd_b;
      OP_LOAD: begin
        if (addr_ok) res_data = mem[mem_idx];
        else         res_err  = 1'b1;
      end
      OP_STORE: begin
        if (addr_ok) res_data = cmd_a;
        else         res_err  = 1'b1;
      end
      default: res_err = 1'b1;
    endcase
  end

  // Registered response; held stable until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_ovf   <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) is_rem_q <= (cmd_op == OP_REM);
          if (accept && !div_start) begin
            rsp_valid <= 1'b1;
            rsp_data  <= res_data;
            rsp_err   <= res_err;
            rsp_ovf   <= res_ovf;
          end
        end
        S_DIV: begin
          if (div_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= is_rem_q ? div_rem : div_quo;
            rsp_err   <= 1'b0;
            rsp_ovf   <= 1'b0;
          end
        end
        S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

  // Data memory write port.
  always_ff @(posedge clk) begin
    // NOTE: memory arrays are deliberately not reset so they map onto RAM and keep contents across reset.
    if (mem_we) mem[mem_idx] <= cmd_a;
  end

  mcu_divider #(
    .DATA_W (DATA_W)
  ) u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (cmd_a),
    .divisor   (cmd_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

endmodule

// File: tb/tb_mcu_exec_unit.sv
// Directed self-checking bench for mcu_exec_unit (DATA_W=32, MEM_DEPTH=16,
// ADDR_W=5). Inputs change 1 time unit after the rising edge; outputs are
// observed at the same point.
module tb_mcu_exec_unit;

  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 16;
  localparam int ADDR_W    = 5;
  localparam int LAT_LIMIT = 100;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [ADDR_W-1:0] cmd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              rsp_ovf;

  int n_asserts = 0;
  int n_fail    = 0;

  mcu_exec_unit #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_addr  (cmd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ovf   (rsp_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, measure latency, check the response, optionally hold
  // rsp_ready low for hold cycles, then complete the handshake.
  task automatic do_cmd(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr, input int exp_lat,
                        input logic [31:0] exp_data, input logic exp_err,
                        input logic exp_ovf, input int hold);
    int k;
    logic ready_seen;
    check({tag, " cmd_ready before"}, 64'(cmd_ready), 64'(1));
    if (hold > 0) rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_addr  = addr;
    step();
    cmd_valid = 1'b0;
    k = 1;
    ready_seen = 1'b0;
    while (!rsp_valid && k < LAT_LIMIT) begin
      if (cmd_ready) ready_seen = 1'b1;
      step();
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(exp_lat));
    check({tag, " data"}, 64'(rsp_data), 64'(exp_data));
    check({tag, " err"}, 64'(rsp_err), 64'(exp_err));
    check({tag, " ovf"}, 64'(rsp_ovf), 64'(exp_ovf));
    if (exp_lat > 1) check({tag, " cmd_ready low while busy"}, 64'(ready_seen), 64'(0));
    for (int h = 0; h < hold; h++) begin
      step();
      check($sformatf("%s hold%0d valid", tag, h), 64'(rsp_valid), 64'(1));
      check($sformatf("%s hold%0d data", tag, h), 64'(rsp_data), 64'(exp_data));
      check($sformatf("%s hold%0d ovf", tag, h), 64'(rsp_ovf), 64'(exp_ovf));
      check($sformatf("%s hold%0d cmd_ready", tag, h), 64'(cmd_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    step();
    check({tag, " valid after handshake"}, 64'(rsp_valid), 64'(0));
    check({tag, " ready after handshake"}, 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    logic seen_valid;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_addr  = '0;
    rsp_ready = 1'b1;

    // Reset state
    step();
    step();
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset rsp_data", 64'(rsp_data), 64'(0));
    check("reset rsp_err", 64'(rsp_err), 64'(0));
    check("reset rsp_ovf", 64'(rsp_ovf), 64'(0));
    check("reset cmd_ready", 64'(cmd_ready), 64'(1));
    reset = 1'b1;
    step();

    // ALU operations
    do_cmd("add 5+7",      4'd0, 32'd5,        32'd7,        5'd0, 1, 32'd12,       1'b0, 1'b0, 0);
    do_cmd("add carry",    4'd0, 32'hFFFFFFFF, 32'd1,        5'd0, 1, 32'd0,        1'b0, 1'b1, 0);
    do_cmd("sub borrow",   4'd1, 32'd3,        32'd5,        5'd0, 1, 32'hFFFFFFFE, 1'b0, 1'b1, 0);
    do_cmd("sub plain",    4'd1, 32'd9,        32'd4,        5'd0, 1, 32'd5,        1'b0, 1'b0, 0);
    do_cmd("mul 3*4",      4'd2, 32'd3,        32'd4,        5'd0, 1, 32'd12,       1'b0, 1'b0, 0);
    do_cmd("and",          4'd4, 32'h0000F0F0, 32'h0000FF00, 5'd0, 1, 32'h0000F000, 1'b0, 1'b0, 0);
    do_cmd("or",           4'd5, 32'h0000F0F0, 32'h0000FF00, 5'd0, 1, 32'h0000FFF0, 1'b0, 1'b0, 0);
    do_cmd("xor",          4'd6, 32'h0000F0F0, 32'h0000FF00, 5'd0, 1, 32'h00000FF0, 1'b0, 1'b0, 0);

    // Divide / remainder, including divide by zero
    do_cmd("div 100/7",    4'd3, 32'd100,      32'd7,        5'd0, 33, 32'd14,      1'b0, 1'b0, 0);
    do_cmd("rem 100/7",    4'd9, 32'd100,      32'd7,        5'd0, 33, 32'd2,       1'b0, 1'b0, 0);
    do_cmd("div max/1",    4'd3, 32'hFFFFFFFF, 32'd1,        5'd0, 33, 32'hFFFFFFFF,1'b0, 1'b0, 0);
    do_cmd("div 9/0",      4'd3, 32'd9,        32'd0,        5'd0, 1, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
    do_cmd("rem 9/0",      4'd9, 32'd9,        32'd0,        5'd0, 1, 32'd9,        1'b1, 1'b0, 0);

    // Memory, including out-of-range address
    do_cmd("store 3",      4'd8, 32'hDEADBEEF, 32'd0,        5'd3, 1, 32'hDEADBEEF, 1'b0, 1'b0, 0);
    do_cmd("load 3",       4'd7, 32'd0,        32'd0,        5'd3, 1, 32'hDEADBEEF, 1'b0, 1'b0, 0);
    do_cmd("store 20",     4'd8, 32'h12345678, 32'd0,        5'd20, 1, 32'd0,       1'b1, 1'b0, 0);
    do_cmd("load 20",      4'd7, 32'd0,        32'd0,        5'd20, 1, 32'd0,       1'b1, 1'b0, 0);
    do_cmd("load 3 again", 4'd7, 32'd0,        32'd0,        5'd3, 1, 32'hDEADBEEF, 1'b0, 1'b0, 0);

    // Backpressure: rsp_ready low for 5 cycles
    do_cmd("mul hold",     4'd2, 32'h00010000, 32'h00010000, 5'd0, 1, 32'd0,        1'b0, 1'b1, 5);

    // Illegal opcode
    do_cmd("op 12",        4'd12, 32'd1,       32'd2,        5'd0, 1, 32'd0,        1'b1, 1'b0, 0);

    // STORE presented while reset is low must not write memory
    do_cmd("store 5",      4'd8, 32'hAAAA5555, 32'd0,        5'd5, 1, 32'hAAAA5555, 1'b0, 1'b0, 0);
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 4'd8;
    cmd_a     = 32'h12345678;
    cmd_addr  = 5'd5;
    step();
    cmd_valid = 1'b0;
    reset     = 1'b1;
    check("store in reset rsp_valid", 64'(rsp_valid), 64'(0));
    do_cmd("load 5",       4'd7, 32'd0,        32'd0,        5'd5, 1, 32'hAAAA5555, 1'b0, 1'b0, 0);

    // Reset at divide cycle 10 discards the pending response
    check("abort cmd_ready before", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_op    = 4'd3;
    cmd_a     = 32'd100;
    cmd_b     = 32'd7;
    step();
    cmd_valid = 1'b0;
    repeat (9) step();
    check("abort cmd_ready mid-divide", 64'(cmd_ready), 64'(0));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort rsp_valid", 64'(rsp_valid), 64'(0));
    check("abort cmd_ready", 64'(cmd_ready), 64'(1));
    seen_valid = 1'b0;
    repeat (40) begin
      step();
      if (rsp_valid) seen_valid = 1'b1;
    end
    check("abort no late response", 64'(seen_valid), 64'(0));
    do_cmd("add 1+1",      4'd0, 32'd1,        32'd1,        5'd0, 1, 32'd2,        1'b0, 1'b0, 0);
    do_cmd("load 3 kept",  4'd7, 32'd0,        32'd0,        5'd3, 1, 32'hDEADBEEF, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
